instr_line_buffer: RTL and testbench
====================================

# instr_line_buffer

Sequential instruction line buffer between the streaming instruction memory (upstream) and the core fetch port (downstream). It requests 512-bit lines by holding the memory enable low and captures each completed line with its line-address tag into a small FIFO. It then serves 32-bit fetch requests from the head line. Lines older than the requested one are discarded; a request for a line already discarded is reported as an error.

## Interface
- DEPTH, 4, number of buffered lines (power of two, ≥2)
- LINE_W, 512, line width in bits (16 words of 32 bits)
- TAG_W, 26, line-address width (byte address bits [31:6])
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- fetch_req  in  1  core fetch request; accepted when fetch_ready=1
- fetch_addr  in  32  byte address; [31:6]=line, [5:2]=word, [1:0] ignored
- fetch_ready  out  1  block is in IDLE and can accept a request
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid
- fetch_data  out  32  fetched instruction word
- fetch_err  out  1  one-cycle pulse; requested line is older than the buffer head and cannot be served
- fill_enb  out  1  memory disable, active-high; 0 = stream lines
- fill_valid  in  1  one-cycle pulse; fill_data holds a complete line
- fill_line_addr  in  TAG_W  memory line pointer; during fill_valid it already points to the NEXT line
- fill_data  in  LINE_W  line data; word k at bits [32k+31:32k]

## Operation
- Fill side:
  - On fill_valid, push {tag = fill_line_addr − 1 (mod 2^TAG_W), fill_data}.
  - fill_enb = (count == DEPTH), combinational.
  - A fill_valid while full is dropped, and count is unchanged.
- Fetch FSM states: IDLE, LOOKUP, RESP.
  - IDLE: fetch_ready=1. On fetch_req, register line=fetch_addr[31:6] and word=fetch_addr[5:2], then go to LOOKUP.
  - LOOKUP, FIFO empty: stay in LOOKUP.
  - LOOKUP, head.tag < line (unsigned): pop head, stay in LOOKUP (skip, one entry per cycle).
  - LOOKUP, head.tag == line: register fetch_data = head.data[32·word +: 32], set fetch_valid, go to RESP. Do not pop; sequential fetches reuse the line.
  - LOOKUP, head.tag > line: set fetch_err, fetch_data=0, go to RESP.
  - RESP: go to IDLE. fetch_valid and fetch_err clear after one cycle.
- Simultaneous push and pop in the same cycle: count is unchanged and both take effect. A push into an empty FIFO is visible to LOOKUP on the following cycle.
- Reset, including mid-lookup: FIFO emptied, FSM to IDLE, any pending request is lost.
- Reset values: fetch_ready=1 (IDLE), fetch_valid=0, fetch_err=0, fetch_data=0, fill_enb=0.

## Timing
- fetch_req is sampled at edge T. LOOKUP runs in cycle T+1. On a head hit, fetch_valid is high in cycle T+2 and fetch_ready returns to 1 in cycle T+3.
- Each discarded stale line adds 1 cycle.
- An empty FIFO adds the wait until fill_valid, plus 1 cycle.
- fill_enb rises the cycle after the push that fills the FIFO. It falls the cycle after the pop that frees an entry.
- No overflow occurs in normal operation because upstream needs ≥32 cycles per line.

## Structure
- Shared package holds:
  - LINE_WORDS=16, WORD_SEL_W=4, LINE_OFF_W=6, TAG_W=26
  - FSM state enum {IDLE, LOOKUP, RESP}
  - entry struct {tag, data}
- One sub-module, line_fifo: a DEPTH-entry synchronous FIFO with push/pop, head outputs, count, full/empty, and wrapping pointers.
- Word mux and FSM live in the top module.

## Test plan
- Reset, then stream lines with fill_line_addr 0x403 and 0x404 at pulses.
  - Tags must be 0x402 and 0x403.
  - Fetch 0x0001_0094 → fetch_data = word 5 of line 0x402, fetch_valid in cycle T+2.
- Fetch 0x0001_0098 right after → word 6 of the same line, no pop, same latency.
- FIFO holds 0x402 to 0x405; fetch 0x0001_0140 (line 0x405).
  - Three pops on consecutive cycles, then a hit.
  - fetch_valid in cycle T+5.
  - fill_enb falls after the first pop.
- Head is 0x405; fetch 0x0001_0000 (line 0x400) → fetch_err pulse, fetch_data=0, FIFO unchanged.
- Fill to DEPTH → fill_enb=1. Inject an extra fill_valid → dropped, count stays 4.
- Assert rstn=0 during LOOKUP with 2 entries → all outputs at reset values, count=0, fill_enb=0 the next cycle.

Source files
------------

// File: rtl/instr_line_buffer_pkg.sv
// rtl/instr_line_buffer_pkg.sv - shared constants, fetch FSM states and line entry type
package instr_line_buffer_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_SEL_W = 4;
    localparam int LINE_OFF_W = 6;
    localparam int TAG_W      = 26;
    localparam int WORD_W     = 32;
    localparam int LINE_BITS  = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } fetch_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [LINE_BITS-1:0] data;
    } line_entry_t;

    function automatic logic [WORD_W-1:0] select_word(
        input logic [LINE_BITS-1:0]  line,
        input logic [WORD_SEL_W-1:0] sel
    );
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/instr_line_buffer_if.sv
// rtl/instr_line_buffer_if.sv - fetch port and line fill port bundle
interface instr_line_buffer_if #(
    parameter int TAG_W  = 26,
    parameter int LINE_W = 512
);

    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic              fetch_err;

    logic              fill_enb;
    logic              fill_valid;
    logic [TAG_W-1:0]  fill_line_addr;
    logic [LINE_W-1:0] fill_data;

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ready,
        output fetch_valid,
        output fetch_data,
        output fetch_err,
        output fill_enb,
        input  fill_valid,
        input  fill_line_addr,
        input  fill_data
    );

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ready,
        input  fetch_valid,
        input  fetch_data,
        input  fetch_err,
        input  fill_enb,
        output fill_valid,
        output fill_line_addr,
        output fill_data
    );

endinterface

// File: rtl/instr_line_buffer_line_fifo.sv
// rtl/instr_line_buffer_line_fifo.sv - DEPTH-entry synchronous FIFO of tagged lines
module line_fifo
    import instr_line_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  line_entry_t      push_entry,
    input  logic             pop,
    output line_entry_t      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    line_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A push into a full FIFO is lost even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push_ok) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instr_line_buffer.sv
// rtl/instr_line_buffer.sv - line buffer between streaming instruction memory and core fetch port
module instr_line_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 512,
    parameter int TAG_W  = 26
) (
    input logic                 clk,
    input logic                 rstn,
    instr_line_buffer_if.slave  bus
);

    import instr_line_buffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [TAG_W-1:0]       line_q;
    logic [WORD_SEL_W-1:0]  word_q;
    logic [31:0]            data_q;
    logic                   valid_q;
    logic                   err_q;

    line_entry_t            push_entry;
    line_entry_t            head;
    logic [LINE_W-1:0]      head_data;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   hit;
    logic                   miss;
    logic                   unused_ok;

    // The memory pointer has already advanced past the line it is delivering.
    always_comb begin
        push_entry      = '0;
        push_entry.tag  = bus.fill_line_addr - 1'b1;
        push_entry.data = bus.fill_data;
    end

    line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (bus.fill_valid),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign head_data = head.data;

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fetch_req) state_next = LOOKUP;
            end
            LOOKUP: begin
                // Stale lines are dropped one per cycle; the hit line stays for sequential fetches.
                if (!fifo_empty) begin
                    if (head.tag < line_q) begin
                        fifo_pop = 1'b1;
                    end else if (head.tag == line_q) begin
                        hit        = 1'b1;
                        state_next = RESP;
                    end else begin
                        miss       = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            line_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            valid_q <= hit;
            err_q   <= miss;
            if (state == IDLE && bus.fetch_req) begin
                line_q <= bus.fetch_addr[LINE_OFF_W +: TAG_W];
                word_q <= bus.fetch_addr[2 +: WORD_SEL_W];
            end
            if (hit) begin
                data_q <= select_word(head_data, word_q);
            end else if (miss) begin
                data_q <= '0;
            end
        end
    end

    assign bus.fetch_ready = (state == IDLE);
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.fetch_data  = data_q;
    assign bus.fill_enb    = fifo_full;

    assign unused_ok = &{1'b0, bus.fetch_addr[1:0], fifo_count};

endmodule

// File: tb/tb_instr_line_buffer.sv
// tb/tb_instr_line_buffer.sv - directed self-checking bench for instr_line_buffer
module tb_instr_line_buffer;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_line_buffer_if bus ();

    instr_line_buffer #(.DEPTH(4), .LINE_W(512), .TAG_W(26)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] make_word(input logic [25:0] tag, input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return {tag, 2'b01, kk};
    endfunction

    function automatic logic [511:0] make_line(input logic [25:0] tag);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = make_word(tag, k);
        return l;
    endfunction

    task automatic fill(input logic [25:0] addr);
        bus.fill_valid     = 1'b1;
        bus.fill_line_addr = addr;
        bus.fill_data      = make_line(addr - 26'd1);
        @(negedge clk);
        bus.fill_valid     = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, output int lat, output logic [31:0] data,
                         output logic err, output logic enb1, output logic enb2,
                         output logic rdy_after, output logic vld_after);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        @(negedge clk);
        bus.fetch_req  = 1'b0;
        lat  = 1;
        enb1 = bus.fill_enb;
        enb2 = 1'b0;
        while (!(bus.fetch_valid || bus.fetch_err) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 2) enb2 = bus.fill_enb;
        end
        data = bus.fetch_data;
        err  = bus.fetch_err;
        @(negedge clk);
        rdy_after = bus.fetch_ready;
        vld_after = bus.fetch_valid | bus.fetch_err;
    endtask

    int          lat;
    logic [31:0] d;
    logic        e, enb1, enb2, rdy, vld;

    initial begin
        rstn               = 1'b0;
        bus.fetch_req      = 1'b0;
        bus.fetch_addr     = '0;
        bus.fill_valid     = 1'b0;
        bus.fill_line_addr = '0;
        bus.fill_data      = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.fetch_ready, 1);
        check("rst_valid", bus.fetch_valid, 0);
        check("rst_err",   bus.fetch_err, 0);
        check("rst_data",  bus.fetch_data, 0);
        check("rst_enb",   bus.fill_enb, 0);
        check("rst_count", u_dut.u_fifo.count, 0);
        rstn = 1'b1;
        @(negedge clk);

        fill(26'h403);
        fill(26'h404);
        check("fill2_count", u_dut.u_fifo.count, 2);
        check("fill2_head",  u_dut.u_fifo.head.tag, 26'h402);

        fetch(32'h0001_0094, lat, d, e, enb1, enb2, rdy, vld);
        check("w5_lat",   lat, 2);
        check("w5_data",  d, make_word(26'h402, 5));
        check("w5_err",   e, 0);
        check("w5_ready", rdy, 1);
        check("w5_pulse", vld, 0);

        fetch(32'h0001_0098, lat, d, e, enb1, enb2, rdy, vld);
        check("w6_lat",   lat, 2);
        check("w6_data",  d, make_word(26'h402, 6));
        check("w6_count", u_dut.u_fifo.count, 2);

        fill(26'h405);
        fill(26'h406);
        check("full_count", u_dut.u_fifo.count, 4);
        check("full_enb",   bus.fill_enb, 1);

        fetch(32'h0001_0140, lat, d, e, enb1, enb2, rdy, vld);
        check("skip_lat",   lat, 5);
        check("skip_data",  d, make_word(26'h405, 0));
        check("skip_enb1",  enb1, 1);
        check("skip_enb2",  enb2, 0);
        check("skip_count", u_dut.u_fifo.count, 1);

        fetch(32'h0001_0000, lat, d, e, enb1, enb2, rdy, vld);
        check("old_lat",   lat, 2);
        check("old_err",   e, 1);
        check("old_data",  d, 0);
        check("old_pulse", vld, 0);
        check("old_count", u_dut.u_fifo.count, 1);
        check("old_head",  u_dut.u_fifo.head.tag, 26'h405);

        fill(26'h407);
        fill(26'h408);
        fill(26'h409);
        check("fill4_enb",   bus.fill_enb, 1);
        fill(26'h40A);
        check("drop_count",  u_dut.u_fifo.count, 4);
        check("drop_head",   u_dut.u_fifo.head.tag, 26'h405);

        fetch(32'h0001_023C, lat, d, e, enb1, enb2, rdy, vld);
        check("w15_lat",   lat, 5);
        check("w15_data",  d, make_word(26'h408, 15));
        check("w15_count", u_dut.u_fifo.count, 1);

        fill(26'h40A);
        check("pre_rst_count", u_dut.u_fifo.count, 2);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0001_0240;
        @(negedge clk);
        check("lookup_busy", bus.fetch_ready, 0);
        bus.fetch_req = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_ready", bus.fetch_ready, 1);
        check("mid_valid", bus.fetch_valid, 0);
        check("mid_err",   bus.fetch_err, 0);
        check("mid_data",  bus.fetch_data, 0);
        check("mid_enb",   bus.fill_enb, 0);
        check("mid_count", u_dut.u_fifo.count, 0);
        rstn = 1'b1;
        @(negedge clk);

        fill(26'h501);
        fetch(32'h0001_4008, lat, d, e, enb1, enb2, rdy, vld);
        check("post_lat",  lat, 2);
        check("post_data", d, make_word(26'h500, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
